// File: rtl/m_scan_sequencer_pkg.sv
// rtl/m_scan_sequencer_pkg.sv - shared constants and state encoding for the scan sequencer
//
// Purpose : select-counter width, sweep end points and FSM state encoding used by
//           m_scan_sequencer and its bench.
package m_scan_sequencer_pkg;

   localparam int SEL_W = 3;

   // Final index of a sweep: 7 when counting up, 0 when counting down.
   localparam logic [SEL_W-1:0] SEL_LAST_UP = 3'd7;
   localparam logic [SEL_W-1:0] SEL_LAST_DN = 3'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/m_scan_sequencer_tick.sv
// rtl/m_scan_sequencer_tick.sv - dwell prescaler producing one tick every div+1 cycles
//
// Purpose : free-running 0..div counter, held at zero while clear is high.
// Ports   : clk   - system clock, rising edge
//           reset - asynchronous active-high reset, counter to 0
//           clear - synchronous hold-at-zero (sequencer not running)
//           div   - terminal count; tick period is div+1 cycles
//           tick  - high in the cycle the counter equals div
module m_tick_prescaler #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] r_cnt;

   // Combinational so the sequencer can act on the tick in the same cycle;
   // div=0 therefore ticks on every cycle of a run.
   assign tick = (r_cnt == div);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clear || tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/m_scan_sequencer.sv
// rtl/m_scan_sequencer.sv - timed 3-bit select sweep feeding a 3-to-8 decoder
//
// Purpose : generates the select sequence {x,y,z} for a downstream 3-to-8 decoder,
//           holding each index div+1 cycles, single-shot or looping, up or down.
// Ports   : clk    - system clock, rising edge
//           reset  - asynchronous active-high reset
//           start  - begin a sweep (IDLE only)
//           stop   - abort a sweep (RUN only, wins over tick)
//           loop   - 1 = wrap continuously, 0 = single sweep (latched at start)
//           dir    - 0 = up 0..7, 1 = down 7..0 (latched at start)
//           div    - dwell minus one per index (latched at start)
//           x,y,z  - select bits 2,1,0
//           active - select carries a valid index
//           busy   - high in RUN and DONE
//           done   - one-cycle pulse at the end of a single sweep
module m_scan_sequencer
   import m_scan_sequencer_pkg::*;
#(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             loop,
   input  logic             dir,
   input  logic [DIV_W-1:0] div,
   output logic             x,
   output logic             y,
   output logic             z,
   output logic             active,
   output logic             busy,
   output logic             done
);

   state_t             r_state, w_state_nx;
   logic [SEL_W-1:0]   r_sel, w_sel_nx;
   logic               r_active, w_active_nx;
   logic               r_busy, w_busy_nx;
   logic               r_done, w_done_nx;
   logic               r_loop, w_loop_nx;
   logic               r_dir, w_dir_nx;
   logic [DIV_W-1:0]   r_div, w_div_nx;
   logic               w_tick;
   logic               w_clear;
   logic [SEL_W-1:0]   w_last;

   // Prescaler only runs in RUN; sitting in IDLE keeps it at zero so the first
   // index of a new sweep gets its full dwell.
   assign w_clear = (r_state != ST_RUN);

   m_tick_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clear (w_clear),
      .div   (r_div),
      .tick  (w_tick)
   );

   assign w_last = r_dir ? SEL_LAST_DN : SEL_LAST_UP;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_sel    <= '0;
         r_active <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_loop   <= 1'b0;
         r_dir    <= 1'b0;
         r_div    <= '0;
      end else begin
         r_state  <= w_state_nx;
         r_sel    <= w_sel_nx;
         r_active <= w_active_nx;
         r_busy   <= w_busy_nx;
         r_done   <= w_done_nx;
         r_loop   <= w_loop_nx;
         r_dir    <= w_dir_nx;
         r_div    <= w_div_nx;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_sel_nx    = r_sel;
      w_active_nx = r_active;
      w_busy_nx   = r_busy;
      w_done_nx   = 1'b0;
      w_loop_nx   = r_loop;
      w_dir_nx    = r_dir;
      w_div_nx    = r_div;

      case (r_state)
         ST_IDLE: begin
            w_sel_nx    = '0;
            w_active_nx = 1'b0;
            w_busy_nx   = 1'b0;
            if (start) begin
               w_loop_nx   = loop;
               w_dir_nx    = dir;
               w_div_nx    = div;
               w_sel_nx    = dir ? SEL_LAST_UP : SEL_LAST_DN;
               w_active_nx = 1'b1;
               w_busy_nx   = 1'b1;
               w_state_nx  = ST_RUN;
            end
         end

         ST_RUN: begin
            if (stop) begin
               w_state_nx  = ST_IDLE;
               w_sel_nx    = '0;
               w_active_nx = 1'b0;
               w_busy_nx   = 1'b0;
            end else if (w_tick) begin
               if ((r_sel == w_last) && !r_loop) begin
                  w_state_nx  = ST_DONE;
                  w_sel_nx    = '0;
                  w_active_nx = 1'b0;
                  w_done_nx   = 1'b1;
               end else begin
                  // Modular 3-bit step also performs the 7->0 / 0->7 loop wrap.
                  w_sel_nx = r_dir ? (r_sel - 3'd1) : (r_sel + 3'd1);
               end
            end
         end

         ST_DONE: begin
            w_state_nx  = ST_IDLE;
            w_busy_nx   = 1'b0;
            w_active_nx = 1'b0;
            w_sel_nx    = '0;
         end

         default: begin
            w_state_nx  = ST_IDLE;
            w_sel_nx    = '0;
            w_active_nx = 1'b0;
            w_busy_nx   = 1'b0;
         end
      endcase
   end

   assign x      = r_sel[2];
   assign y      = r_sel[1];
   assign z      = r_sel[0];
   assign active = r_active;
   assign busy   = r_busy;
   assign done   = r_done;

endmodule

// File: tb/tb_m_scan_sequencer.sv
// tb/tb_m_scan_sequencer.sv - self-checking bench for m_scan_sequencer
module tb_m_scan_sequencer;

   localparam int DIV_W = 8;

   logic             clk;
   logic             reset;
   logic             start;
   logic             stop;
   logic             loop;
   logic             dir;
   logic [DIV_W-1:0] div;
   logic             x, y, z;
   logic             active, busy, done;
   logic [7:0]       w_onehot;

   int n_checks = 0;
   int n_errors = 0;

   // Expected post-edge state: {sel[2:0], active, busy, done}
   logic [5:0] exp_q[$];

   m_scan_sequencer #(.DIV_W(DIV_W)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .stop   (stop),
      .loop   (loop),
      .dir    (dir),
      .div    (div),
      .x      (x),
      .y      (y),
      .z      (z),
      .active (active),
      .busy   (busy),
      .done   (done)
   );

   // Stand-in for the downstream 3-to-8 decoder.
   assign w_onehot = 8'd1 << {x, y, z};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int s, input logic a, input logic b, input logic d);
      logic [2:0] s3;
      s3 = 3'(s);
      exp_q.push_back({s3, a, b, d});
   endtask

   task automatic cycle();
      logic [5:0] e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $error("FAIL scoreboard observed=empty expected=entry");
      end else begin
         e = exp_q.pop_front();
         chk("sel", {5'b0, x, y, z}, {5'b0, e[5:3]});
         chk("flags", {5'b0, active, busy, done}, {5'b0, e[2:0]});
         if (e[2]) chk("onehot", w_onehot, 8'd1 << e[5:3]);
      end
   endtask

   task automatic check_idle_now(input string tag);
      chk(tag, {2'b0, x, y, z, active, busy, done}, 8'h00);
   endtask

   // Single-shot sweep; when hold is set, start stays high through RUN and DONE.
   task automatic sweep(input logic d, input int dv, input logic hold);
      start = 1'b1;
      loop  = 1'b0;
      dir   = d;
      div   = DIV_W'(dv);
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j <= dv; j++) begin
            push(d ? 7 - i : i, 1'b1, 1'b1, 1'b0);
            cycle();
            start = hold;
            // Latched inputs must not matter mid-run.
            dir   = ~d;
            div   = DIV_W'(dv + 3);
         end
      end
      push(0, 1'b0, 1'b1, 1'b1);
      cycle();
      push(0, 1'b0, 1'b0, 1'b0);
      cycle();
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      loop  = 1'b0;
      dir   = 1'b0;
      div   = '0;
      #1;
      check_idle_now("reset_state");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Idle with start low.
      for (int i = 0; i < 20; i++) begin
         push(0, 1'b0, 1'b0, 1'b0);
         cycle();
      end

      // Single-shot up, div=0, then down, div=2.
      sweep(1'b0, 0, 1'b0);
      sweep(1'b1, 2, 1'b0);

      // Loop up, div=1: 39 cycles then stop on first cycle of index 3.
      start = 1'b1;
      loop  = 1'b1;
      dir   = 1'b0;
      div   = 8'd1;
      for (int c = 0; c < 39; c++) begin
         push((c / 2) % 8, 1'b1, 1'b1, 1'b0);
         cycle();
         start = 1'b0;
         loop  = 1'b0;
      end
      stop = 1'b1;
      push(0, 1'b0, 1'b0, 1'b0);
      cycle();
      stop = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push(0, 1'b0, 1'b0, 1'b0);
         cycle();
      end

      // Start held through RUN and DONE, then accepted right after done falls.
      sweep(1'b0, 1, 1'b1);
      sweep(1'b1, 0, 1'b0);

      // Async reset mid-cycle while sel=5.
      start = 1'b1;
      dir   = 1'b0;
      loop  = 1'b0;
      div   = 8'd0;
      for (int i = 0; i < 6; i++) begin
         push(i, 1'b1, 1'b1, 1'b0);
         cycle();
         start = 1'b0;
      end
      #2;
      reset = 1'b1;
      #1;
      check_idle_now("async_reset");
      @(posedge clk);
      #1;
      check_idle_now("reset_held");
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push(0, 1'b0, 1'b0, 1'b0);
         cycle();
      end
      sweep(1'b0, 0, 1'b0);

      n_checks++;
      assert (exp_q.size() == 0) else begin
         n_errors++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
